// File: rtl/rv32_exec_ctrl.sv
// rv32_exec_ctrl: single-cycle RV32I control decode, ALU and next-PC adder plus clocked status.
// Define EXEC_EBREAK_EN to decode EBREAK and enable the sticky halt flag.
`timescale 1ns/1ps
module rv32_exec_ctrl #(
  parameter int unsigned XLEN            = 32,
  parameter int unsigned RESET_PC_UNUSED = 0
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [XLEN-1:0] cmd,
  input  logic [XLEN-1:0] pc,
  input  logic [XLEN-1:0] src1,
  input  logic [XLEN-1:0] src2,
  input  logic [XLEN-1:0] imm,
  output logic [2:0]      op_IMM,
  output logic            en_Wreg,
  output logic            load,
  output logic            store,
  output logic [XLEN-1:0] result,
  output logic            LESS,
  output logic            IS_ZERO,
  output logic [XLEN-1:0] dnpc,
  output logic            illegal,
  output logic [XLEN-1:0] instret,
  output logic            halt
);

  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_SYSTEM = 7'b1110011;
`ifdef EXEC_EBREAK_EN
  localparam logic [31:0] EBREAK_WORD = 32'h0010_0073;
`endif

  typedef enum logic [3:0] {
    ALU_ADD   = 4'd0,
    ALU_SUB   = 4'd1,
    ALU_SLL   = 4'd2,
    ALU_SLT   = 4'd3,
    ALU_SLTU  = 4'd4,
    ALU_XOR   = 4'd5,
    ALU_SRL   = 4'd6,
    ALU_SRA   = 4'd7,
    ALU_OR    = 4'd8,
    ALU_AND   = 4'd9,
    ALU_PASSB = 4'd10
  } alu_op_e;

  typedef enum logic [1:0] {
    B_SRC2 = 2'd0,
    B_IMM  = 2'd1,
    B_FOUR = 2'd2
  } b_sel_e;

  // Register-register and register-immediate ops share the funct3 map; alt picks SUB/SRA.
  function automatic alu_op_e f3_to_op(input logic [2:0] f3, input logic alt);
    case (f3)
      3'b000:  f3_to_op = alt ? ALU_SUB : ALU_ADD;
      3'b001:  f3_to_op = ALU_SLL;
      3'b010:  f3_to_op = ALU_SLT;
      3'b011:  f3_to_op = ALU_SLTU;
      3'b100:  f3_to_op = ALU_XOR;
      3'b101:  f3_to_op = alt ? ALU_SRA : ALU_SRL;
      3'b110:  f3_to_op = ALU_OR;
      default: f3_to_op = ALU_AND;
    endcase
  endfunction

  logic [6:0]      opcode_s;
  logic [2:0]      funct3_s;
  logic            alt_s;
  logic [2:0]      op_imm_s;
  logic            wreg_s, load_s, store_s;
  logic            a_pc_s, jal_s, jalr_s, branch_s;
  logic            illegal_s, ebreak_s, taken_s;
  b_sel_e          b_sel_s;
  alu_op_e         alu_op_s;
  logic [XLEN-1:0] op_a_s, op_b_s, alu_s;
  logic [XLEN-1:0] npc_a_s, npc_b_s, npc_sum_s;
  logic            lt_s, ltu_s;
  logic [4:0]      shamt_s;
  logic            illegal_r;
  logic [XLEN-1:0] instret_r;
  logic            unused_s;

  assign opcode_s = cmd[6:0];
  assign funct3_s = cmd[14:12];
  assign alt_s    = cmd[30];

  // Control decoder: opcode/funct3 to operand selects, ALU op and side-effect enables.
  always_comb begin
    op_imm_s  = 3'd7;
    wreg_s    = 1'b0;
    load_s    = 1'b0;
    store_s   = 1'b0;
    a_pc_s    = 1'b0;
    jal_s     = 1'b0;
    jalr_s    = 1'b0;
    branch_s  = 1'b0;
    illegal_s = 1'b0;
    ebreak_s  = 1'b0;
    b_sel_s   = B_SRC2;
    alu_op_s  = ALU_ADD;
    case (opcode_s)
      OPC_LUI: begin
        op_imm_s = 3'd3; wreg_s = 1'b1; b_sel_s = B_IMM; alu_op_s = ALU_PASSB;
      end
      OPC_AUIPC: begin
        op_imm_s = 3'd3; wreg_s = 1'b1; a_pc_s = 1'b1; b_sel_s = B_IMM;
      end
      OPC_JAL: begin
        op_imm_s = 3'd4; wreg_s = 1'b1; a_pc_s = 1'b1; b_sel_s = B_FOUR; jal_s = 1'b1;
      end
      OPC_JALR: begin
        if (funct3_s == 3'b000) begin
          op_imm_s = 3'd0; wreg_s = 1'b1; a_pc_s = 1'b1; b_sel_s = B_FOUR; jalr_s = 1'b1;
        end else begin
          illegal_s = 1'b1;
        end
      end
      OPC_BRANCH: begin
        op_imm_s = 3'd2;
        branch_s = 1'b1;
        case (funct3_s)
          3'b000, 3'b001: alu_op_s = ALU_SUB;
          3'b100, 3'b101: alu_op_s = ALU_SLT;
          3'b110, 3'b111: alu_op_s = ALU_SLTU;
          default: begin
            branch_s  = 1'b0;
            illegal_s = 1'b1;
          end
        endcase
      end
      OPC_LOAD: begin
        op_imm_s = 3'd0; b_sel_s = B_IMM;
        case (funct3_s)
          3'b000, 3'b001, 3'b010, 3'b100, 3'b101: begin
            load_s = 1'b1; wreg_s = 1'b1;
          end
          default: illegal_s = 1'b1;
        endcase
      end
      OPC_STORE: begin
        op_imm_s = 3'd1; b_sel_s = B_IMM;
        case (funct3_s)
          3'b000, 3'b001, 3'b010: store_s = 1'b1;
          default: illegal_s = 1'b1;
        endcase
      end
      OPC_OPIMM: begin
        op_imm_s = 3'd0; wreg_s = 1'b1; b_sel_s = B_IMM;
        alu_op_s = f3_to_op(funct3_s, alt_s & (funct3_s == 3'b101));
      end
      OPC_OP: begin
        wreg_s   = 1'b1;
        alu_op_s = f3_to_op(funct3_s, alt_s);
      end
      OPC_SYSTEM: begin
`ifdef EXEC_EBREAK_EN
        if (cmd == EBREAK_WORD) begin
          ebreak_s = 1'b1;
        end else begin
          illegal_s = 1'b1;
        end
`else
        illegal_s = 1'b1;
`endif
      end
      default: illegal_s = 1'b1;
    endcase
  end

  assign op_a_s = a_pc_s ? pc : src1;

  // Operand B select.
  always_comb begin
    case (b_sel_s)
      B_SRC2:  op_b_s = src2;
      B_IMM:   op_b_s = imm;
      B_FOUR:  op_b_s = {{(XLEN-3){1'b0}}, 3'd4};
      default: op_b_s = src2;
    endcase
  end

  assign lt_s    = $signed(op_a_s) < $signed(op_b_s);
  assign ltu_s   = op_a_s < op_b_s;
  assign shamt_s = op_b_s[4:0];

  // ALU datapath.
  always_comb begin
    case (alu_op_s)
      ALU_ADD:   alu_s = op_a_s + op_b_s;
      ALU_SUB:   alu_s = op_a_s - op_b_s;
      ALU_SLL:   alu_s = op_a_s << shamt_s;
      ALU_SLT:   alu_s = {{(XLEN-1){1'b0}}, lt_s};
      ALU_SLTU:  alu_s = {{(XLEN-1){1'b0}}, ltu_s};
      ALU_XOR:   alu_s = op_a_s ^ op_b_s;
      ALU_SRL:   alu_s = op_a_s >> shamt_s;
      ALU_SRA:   alu_s = $unsigned($signed(op_a_s) >>> shamt_s);
      ALU_OR:    alu_s = op_a_s | op_b_s;
      ALU_AND:   alu_s = op_a_s & op_b_s;
      ALU_PASSB: alu_s = op_b_s;
      default:   alu_s = op_a_s + op_b_s;
    endcase
  end

  assign result  = alu_s;
  assign LESS    = (alu_op_s == ALU_SLTU) ? ltu_s : lt_s;
  assign IS_ZERO = (alu_s == {XLEN{1'b0}});

  // Branch resolution reuses the ALU flags: SUB for equality, SLT/SLTU for ordering.
  always_comb begin
    case (funct3_s)
      3'b000:         taken_s = IS_ZERO;
      3'b001:         taken_s = !IS_ZERO;
      3'b100, 3'b110: taken_s = LESS;
      3'b101, 3'b111: taken_s = !LESS;
      default:        taken_s = 1'b0;
    endcase
  end

  // Next-PC adder operand select; falls through to pc+4.
  always_comb begin
    npc_a_s = {{(XLEN-3){1'b0}}, 3'd4};
    npc_b_s = pc;
    if (jal_s) begin
      npc_a_s = imm;
      npc_b_s = pc;
    end else if (jalr_s) begin
      npc_a_s = imm;
      npc_b_s = src1;
    end else if (branch_s && taken_s) begin
      npc_a_s = imm;
      npc_b_s = pc;
    end else begin
      npc_a_s = {{(XLEN-3){1'b0}}, 3'd4};
      npc_b_s = pc;
    end
  end

  assign npc_sum_s = npc_a_s + npc_b_s;
  assign dnpc      = jalr_s ? {npc_sum_s[XLEN-1:1], 1'b0} : npc_sum_s;

  assign op_IMM  = illegal_s ? 3'd7 : op_imm_s;
  assign en_Wreg = wreg_s  & ~rst;
  assign load    = load_s  & ~rst;
  assign store   = store_s & ~rst;

  // Sticky illegal flag and retired-instruction counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      illegal_r <= 1'b0;
      instret_r <= {XLEN{1'b0}};
    end else begin
      illegal_r <= illegal_r | illegal_s;
      if (!halt && !illegal_s) begin
        instret_r <= instret_r + {{(XLEN-1){1'b0}}, 1'b1};
      end
    end
  end

  assign illegal = illegal_r;
  assign instret = instret_r;

`ifdef EXEC_EBREAK_EN
  logic halt_r;

  // Sticky halt once EBREAK retires.
  always_ff @(posedge clk) begin
    if (rst) begin
      halt_r <= 1'b0;
    end else begin
      halt_r <= halt_r | ebreak_s;
    end
  end

  assign halt     = halt_r;
  assign unused_s = ^{cmd[31], cmd[29:15], cmd[11:7], RESET_PC_UNUSED[0]};
`else
  assign halt     = 1'b0;
  assign unused_s = ^{cmd[31], cmd[29:15], cmd[11:7], RESET_PC_UNUSED[0], ebreak_s};
`endif

endmodule

// File: tb/tb_rv32_exec_ctrl.sv
// Scoreboard bench for rv32_exec_ctrl: directed vectors plus random instructions checked
// against an instruction-level reference model.
`timescale 1ns/1ps
module tb_rv32_exec_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] cmd = 32'd0, pc = 32'd0, src1 = 32'd0, src2 = 32'd0, imm = 32'd0;
  logic [2:0]  op_IMM;
  logic        en_Wreg, load, store, LESS, IS_ZERO, illegal, halt;
  logic [31:0] result, dnpc, instret;

  rv32_exec_ctrl dut (
    .clk(clk), .rst(rst), .cmd(cmd), .pc(pc), .src1(src1), .src2(src2), .imm(imm),
    .op_IMM(op_IMM), .en_Wreg(en_Wreg), .load(load), .store(store), .result(result),
    .LESS(LESS), .IS_ZERO(IS_ZERO), .dnpc(dnpc), .illegal(illegal), .instret(instret),
    .halt(halt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] cmd;
    logic [2:0]  op_imm;
    logic        wreg, ld, st, less, zero, chk_alu, is_ill, is_ebreak;
    logic [31:0] result, dnpc;
    logic        ill, hlt;
    logic [31:0] iret;
  } vec_t;

  vec_t        sb_q[$];
  logic        vec_valid = 1'b0;
  int          n_vec = 0;
  int          n_err = 0;
  logic        m_ill = 1'b0, m_halt = 1'b0;
  logic [31:0] m_iret = 32'd0;

  // Instruction-level reference: each RV32I instruction's architectural effect.
  function automatic vec_t model(input logic [31:0] c, input logic [31:0] p,
                                 input logic [31:0] s1, input logic [31:0] s2,
                                 input logic [31:0] im, input logic r);
    vec_t e;
    logic [6:0]  opc;
    logic [2:0]  f3;
    logic [31:0] a, b;
    logic        uns;
    opc = c[6:0];
    f3  = c[14:12];
    e.cmd = c; e.op_imm = 3'd7; e.wreg = 1'b0; e.ld = 1'b0; e.st = 1'b0;
    e.chk_alu = 1'b1; e.is_ill = 1'b0; e.is_ebreak = 1'b0;
    e.result = 32'd0; e.dnpc = p + 32'd4; e.ill = 1'b0; e.hlt = 1'b0; e.iret = 32'd0;
    a = s1; b = s2; uns = 1'b0;
    case (opc)
      7'b0110111: begin e.op_imm = 3'd3; e.wreg = 1'b1; b = im; e.result = im; end
      7'b0010111: begin e.op_imm = 3'd3; e.wreg = 1'b1; a = p; b = im; e.result = p + im; end
      7'b1101111: begin
        e.op_imm = 3'd4; e.wreg = 1'b1; a = p; b = 32'd4; e.result = p + 32'd4; e.dnpc = p + im;
      end
      7'b1100111: begin
        if (f3 == 3'd0) begin
          e.op_imm = 3'd0; e.wreg = 1'b1; a = p; b = 32'd4; e.result = p + 32'd4;
          e.dnpc = (s1 + im) & 32'hFFFF_FFFE;
        end else e.is_ill = 1'b1;
      end
      7'b1100011: begin
        logic tk;
        tk = 1'b0;
        e.op_imm = 3'd2;
        case (f3)
          3'd0: begin e.result = s1 - s2; tk = (s1 == s2); end
          3'd1: begin e.result = s1 - s2; tk = (s1 != s2); end
          3'd4: begin tk = $signed(s1) < $signed(s2);   e.result = {31'd0, tk}; end
          3'd5: begin tk = !($signed(s1) < $signed(s2)); e.result = {31'd0, !tk}; end
          3'd6: begin tk = s1 < s2;  uns = 1'b1; e.result = {31'd0, tk}; end
          3'd7: begin tk = s1 >= s2; uns = 1'b1; e.result = {31'd0, !tk}; end
          default: e.is_ill = 1'b1;
        endcase
        if (tk) e.dnpc = p + im;
      end
      7'b0000011: begin
        e.op_imm = 3'd0; b = im; e.result = s1 + im;
        if (f3 == 3'd3 || f3 > 3'd5) e.is_ill = 1'b1;
        else begin e.ld = 1'b1; e.wreg = 1'b1; end
      end
      7'b0100011: begin
        e.op_imm = 3'd1; b = im; e.result = s1 + im;
        if (f3 > 3'd2) e.is_ill = 1'b1; else e.st = 1'b1;
      end
      7'b0010011, 7'b0110011: begin
        logic is_op;
        is_op = (opc == 7'b0110011);
        if (!is_op) begin e.op_imm = 3'd0; b = im; end
        e.wreg = 1'b1;
        case (f3)
          3'd0: e.result = (is_op && c[30]) ? a - b : a + b;
          3'd1: e.result = a << b[4:0];
          3'd2: e.result = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
          3'd3: begin e.result = (a < b) ? 32'd1 : 32'd0; uns = 1'b1; end
          3'd4: e.result = a ^ b;
          3'd5: e.result = c[30] ? $unsigned($signed(a) >>> b[4:0]) : a >> b[4:0];
          3'd6: e.result = a | b;
          default: e.result = a & b;
        endcase
      end
`ifdef EXEC_EBREAK_EN
      7'b1110011: begin
        if (c == 32'h0010_0073) begin e.is_ebreak = 1'b1; e.chk_alu = 1'b0; end
        else e.is_ill = 1'b1;
      end
`endif
      default: e.is_ill = 1'b1;
    endcase
    if (e.is_ill) begin
      e.op_imm = 3'd7; e.wreg = 1'b0; e.ld = 1'b0; e.st = 1'b0;
      e.chk_alu = 1'b0; e.dnpc = p + 32'd4;
    end
    e.less = uns ? (a < b) : ($signed(a) < $signed(b));
    e.zero = (e.result == 32'd0);
    if (r) begin e.wreg = 1'b0; e.ld = 1'b0; e.st = 1'b0; end
    return e;
  endfunction

  task automatic apply(input logic [31:0] c, input logic [31:0] p, input logic [31:0] s1,
                       input logic [31:0] s2, input logic [31:0] im, input logic r);
    vec_t v;
    @(posedge clk);
    #1;
    cmd = c; pc = p; src1 = s1; src2 = s2; imm = im; rst = r;
    v = model(c, p, s1, s2, im, r);
    v.ill = m_ill; v.iret = m_iret; v.hlt = m_halt;
    if (r) begin
      m_ill = 1'b0; m_iret = 32'd0; m_halt = 1'b0;
    end else begin
      m_ill = m_ill | v.is_ill;
      if (!m_halt && !v.is_ill) m_iret = m_iret + 32'd1;
      m_halt = m_halt | v.is_ebreak;
    end
    sb_q.push_back(v);
    vec_valid = 1'b1;
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp_v,
                     input logic [31:0] c);
    if (act !== exp_v) begin
      n_err++;
      $display("FAIL %s: cmd=%08h got %08h expected %08h", nm, c, act, exp_v);
    end
  endtask

  // Monitor: pop the expected response for the vector currently on the DUT inputs.
  always @(negedge clk) begin
    if (vec_valid) begin
      if (sb_q.size() == 0) begin
        n_err++;
        $display("FAIL scoreboard: output with no expected entry");
      end else begin
        vec_t e;
        e = sb_q.pop_front();
        n_vec++;
        chk("op_IMM",  {29'd0, op_IMM}, {29'd0, e.op_imm}, e.cmd);
        chk("en_Wreg", {31'd0, en_Wreg}, {31'd0, e.wreg}, e.cmd);
        chk("load",    {31'd0, load},    {31'd0, e.ld},   e.cmd);
        chk("store",   {31'd0, store},   {31'd0, e.st},   e.cmd);
        chk("dnpc",    dnpc,             e.dnpc,          e.cmd);
        chk("illegal", {31'd0, illegal}, {31'd0, e.ill},  e.cmd);
        chk("instret", instret,          e.iret,          e.cmd);
        chk("halt",    {31'd0, halt},    {31'd0, e.hlt},  e.cmd);
        if (e.chk_alu) begin
          chk("result",  result,            e.result,        e.cmd);
          chk("LESS",    {31'd0, LESS},     {31'd0, e.less}, e.cmd);
          chk("IS_ZERO", {31'd0, IS_ZERO},  {31'd0, e.zero}, e.cmd);
        end
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  localparam logic [6:0] OPCS [9] = '{7'b0110111, 7'b0010111, 7'b1101111, 7'b1100111,
                                       7'b1100011, 7'b0000011, 7'b0100011, 7'b0010011,
                                       7'b0110011};

  initial begin
    repeat (3) @(posedge clk);
    // Reset outranks an illegal word; then the directed cases.
    apply(32'h0000_0000, 32'h8000_0000, 32'd0, 32'd0, 32'd0, 1'b1);
    apply(32'h0050_0093, 32'h8000_0000, 32'd0, 32'd0, 32'd5, 1'b0);
    apply(32'h4020_8033, 32'h8000_0004, 32'd3, 32'd5, 32'd0, 1'b0);
    apply(32'h0020_8463, 32'h8000_0000, 32'd7, 32'd7, 32'd8, 1'b0);
    apply(32'h0020_8463, 32'h8000_0000, 32'd7, 32'd6, 32'd8, 1'b0);
    apply(32'h0000_80E7, 32'h8000_0100, 32'h8000_0011, 32'd0, 32'd0, 1'b0);
    apply(32'h1234_50B7, 32'h8000_0104, 32'd0, 32'd0, 32'h1234_5000, 1'b0);
    apply(32'h0000_0000, 32'h8000_0108, 32'd1, 32'd2, 32'd3, 1'b0);
    apply(32'h0050_0093, 32'h8000_010C, 32'd0, 32'd0, 32'd5, 1'b0);
    apply(32'h0050_0093, 32'h8000_0110, 32'd0, 32'd0, 32'd5, 1'b1);
    apply(32'h0010_0073, 32'h8000_0000, 32'd0, 32'd0, 32'd0, 1'b0);
    apply(32'h0050_0093, 32'h8000_0004, 32'd0, 32'd0, 32'd5, 1'b0);
    apply(32'h0050_0093, 32'h8000_0008, 32'd0, 32'd0, 32'd5, 1'b0);
    apply(32'h0050_0093, 32'h8000_000C, 32'd0, 32'd0, 32'd5, 1'b1);
    for (int i = 0; i < 600; i++) begin
      int unsigned sel;
      logic [31:0] c, s1, s2, im;
      sel = $urandom_range(0, 31);
      c   = $urandom;
      if (sel < 27) c[6:0] = OPCS[sel % 9];
      else if (sel < 29) c = 32'd0;
      else if (sel == 29) c = 32'h0010_0073;
      s1 = $urandom;
      s2 = ($urandom_range(0, 3) == 0) ? s1 : $urandom;
      im = ($urandom_range(0, 1) == 0) ? $urandom : ($urandom & 32'h0000_0FFF);
      apply(c, $urandom & 32'hFFFF_FFFC, s1, s2, im, (i % 50) == 49);
    end
    @(posedge clk);
    #1;
    vec_valid = 1'b0;
    repeat (2) @(negedge clk);
    if (sb_q.size() != 0) begin
      n_err++;
      $display("FAIL drain: %0d expected entries never checked", sb_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
